// File: rtl/crc_stream_if.sv
// Handshake bundle for crc_stream: frame control, input word stream and held result.
// The engine takes the slave side; the stream source and the result consumer drive the master side.
interface crc_stream_if #(
    parameter int CRC_W  = 16,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic [CRC_W-1:0]  seed;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [CRC_W-1:0]  m_crc;
    logic [CNT_W-1:0]  m_len;
    logic              busy;
`ifdef CRC_STREAM_CHECK_EN
    logic [CRC_W-1:0]  chk_crc;
    logic              m_match;
`endif

    modport master (
        output seed, start, s_valid, s_data, s_last, m_ready,
`ifdef CRC_STREAM_CHECK_EN
        output chk_crc,
        input  m_match,
`endif
        input  s_ready, m_valid, m_crc, m_len, busy
    );

    modport slave (
        input  seed, start, s_valid, s_data, s_last, m_ready,
`ifdef CRC_STREAM_CHECK_EN
        input  chk_crc,
        output m_match,
`endif
        output s_ready, m_valid, m_crc, m_len, busy
    );
endinterface

// File: rtl/crc_stream.sv
// Framed streaming CRC engine (generic width/poly/reflection); CRC_STREAM_CHECK_EN adds chk_crc compare -> m_match.
// Latency: result valid the cycle after the last beat is accepted (3 cycles start->result minimum).
// Backpressure: s_ready only in RUN; result held in DONE until m_ready, new frames need start in IDLE.
module crc_stream #(
    parameter int               CRC_W  = 16,
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT = '0,
    parameter int               CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    crc_stream_if.slave strm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            fb = r[CRC_W-1] ^ (REFIN ? d[i] : d[DATA_W-1-i]);
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] crc_final(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = REFOUT ? c[CRC_W-1-i] : c[i];
        end
        return r ^ XOROUT;
    endfunction

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CRC_W-1:0] crc_nxt;
    logic [CRC_W-1:0] res_nxt;
    logic [CNT_W-1:0] cnt_inc;
`ifdef CRC_STREAM_CHECK_EN
    logic [CRC_W-1:0] chk_q, chk_d;
    logic             match_q, match_d;
`endif

    assign crc_nxt = crc_fold(crc_q, strm.s_data);
    assign res_nxt = crc_final(crc_nxt);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        len_d   = len_q;
`ifdef CRC_STREAM_CHECK_EN
        chk_d   = chk_q;
        match_d = match_q;
`endif
        case (state_q)
            IDLE: begin
                if (strm.start) begin
                    crc_d   = strm.seed;
                    cnt_d   = '0;
`ifdef CRC_STREAM_CHECK_EN
                    chk_d   = strm.chk_crc;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // start restarts the frame and drops any beat offered in the same cycle
                if (strm.start) begin
                    crc_d = strm.seed;
                    cnt_d = '0;
`ifdef CRC_STREAM_CHECK_EN
                    chk_d = strm.chk_crc;
`endif
                end else if (strm.s_valid) begin
                    crc_d = crc_nxt;
                    cnt_d = cnt_inc;
                    if (strm.s_last) begin
                        res_d   = res_nxt;
                        len_d   = cnt_inc;
`ifdef CRC_STREAM_CHECK_EN
                        match_d = (res_nxt == chk_q);
`endif
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (strm.m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            len_q   <= '0;
`ifdef CRC_STREAM_CHECK_EN
            chk_q   <= '0;
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            len_q   <= len_d;
`ifdef CRC_STREAM_CHECK_EN
            chk_q   <= chk_d;
            match_q <= match_d;
`endif
        end
    end

    assign strm.s_ready = (state_q == RUN);
    assign strm.m_valid = (state_q == DONE);
    assign strm.busy    = (state_q != IDLE);
    assign strm.m_crc   = res_q;
    assign strm.m_len   = len_q;
`ifdef CRC_STREAM_CHECK_EN
    assign strm.m_match = match_q;
`endif

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
- Parametrised streaming CRC engine; next generation of the team's fixed CRC-16/0x1021 byte engine.
- Generic width, polynomial, input word width, input/output reflection and final XOR.
- Adds valid/ready handshakes on both sides, frame delimiting (start/last), a held result with a beat count, and an optional check mode.
- Sits between a byte/word stream source (AXI-stream-like wrapper) and register-mapped result logic in the custom CRC IP.

Parameters:
- CRC_W, 16, CRC register width (1..64).
- DATA_W, 8, input word width processed per accepted beat (1..64).
- POLY, 16'h1021, generator polynomial, implicit top bit omitted, normal (non-reflected) form.
- REFIN, 0, 1 = each input word processed LSB-first; 0 = MSB-first.
- REFOUT, 0, 1 = final CRC bit-reversed before XOROUT.
- XOROUT, 0, value XORed into the result after optional reflection.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- seed  in  CRC_W  initial register value, sampled on the cycle start is accepted.
- start  in  1  begin a frame: load seed, enter RUN.
- s_valid  in  1  input word valid.
- s_ready  out  1  engine accepts a word this cycle.
- s_data  in  DATA_W  input word.
- s_last  in  1  qualifies the final word of a frame.
- m_valid  out  1  result valid, held until taken.
- m_ready  in  1  result consumer ready.
- m_crc  out  CRC_W  final CRC (reflection and XOROUT applied).
- m_len  out  CNT_W  beats accepted in the frame, saturating.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; crc register=0; count=0; s_ready=0, m_valid=0, m_crc=0, m_len=0, busy=0.
- States: IDLE, RUN, DONE.
  - IDLE: s_ready=0. start=1 → crc<=seed, count<=0, next RUN. s_valid is ignored.
  - RUN: s_ready=1. A beat is accepted when s_valid&s_ready, and then crc<=next(crc,s_data) with all DATA_W bits folded in one cycle; count<=count+1, saturating at all-ones.
    - Beat with s_last=1 → next DONE. On the same edge, m_crc<=final(next) and m_len<=count+1 (saturating); m_valid rises the next cycle.
    - start=1 in RUN aborts the frame: crc<=seed, count<=0, stay in RUN, and any beat in that cycle is discarded. start has priority over data.
  - DONE: s_ready=0; m_valid=1; m_crc and m_len stable. m_valid&m_ready → next IDLE, m_valid<=0. start in DONE is ignored; a new frame needs start in IDLE.
- next(): per bit, MSB of s_data first when REFIN=0, bit 0 first when REFIN=1. fb=crc[CRC_W-1]^bit; crc=(crc<<1)^(fb?POLY:0), truncated to CRC_W.
- final(x): (REFOUT ? bitreverse(x) : x) ^ XOROUT.
- Latency: last beat accepted at edge N → m_valid=1 after edge N; minimum frame is 1 beat, giving 3 cycles start→result.
- Single-beat frame: start, then a beat with s_last=1, → m_len=1.
- m_len saturates at 2^CNT_W-1; m_crc is still correct for any frame length.
- Reset mid-frame: immediate return to IDLE; partial CRC is lost and no m_valid is produced.
- Combinational outputs are not allowed; all outputs are registered or decoded from the state register.

Optional Feature:
- Macro CRC_STREAM_CHECK_EN.
- When defined:
  - Extra input chk_crc[CRC_W], sampled together with start.
  - Extra output m_match: registered on the last beat as (final(next)==chk_crc), valid with m_valid, reset 0.
- When undefined: the ports are absent and there is no compare logic.

Test Plan:
- Defaults, seed=16'hFFFF, "123456789" (0x31..0x39), s_last on 0x39 → m_crc=16'h29B1, m_len=9.
- Defaults, seed=0, same 9 bytes with s_valid toggling randomly → m_crc=16'h31C3, m_len=9; no beat lost or duplicated.
- CRC_W=32, POLY=32'h04C11DB7, REFIN=REFOUT=1, XOROUT=32'hFFFFFFFF, seed=32'hFFFFFFFF, "123456789" → m_crc=32'hCBF43926.
- m_ready held 0 for 20 cycles in DONE → m_valid and m_crc stable, s_ready=0, extra start ignored. m_ready=1 → IDLE next cycle.
- start reasserted after 4 beats of a frame, then "123456789" with seed=16'hFFFF → 16'h29B1, m_len=9. rst pulsed mid-frame → all outputs 0 while rst=1 and after, until the next start.
- CRC_STREAM_CHECK_EN, CNT_W=3, chk_crc=16'h29B1 → m_match=1, m_len=7 (saturated). Repeat with chk_crc=16'h29B0 → m_match=0.
